// File: rtl/uart_crc_framer_if.sv
// ============================================================================
//  Module      : uart_crc_framer_if
//  Description : Bundle of the framer's payload input stream, byte output
//                stream toward the UART transmitter, CRC engine controls and
//                frame status outputs.
//                master : the framer side (drives s_ready, m_*, crc_* strobes,
//                         status outputs)
//                slave  : the surrounding system (producer, UART TX, CRC
//                         engine, status consumer)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_crc_framer_if;
  // Payload stream from the byte producer
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;
  // Byte stream toward the UART transmitter
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  // Shared CRC-8 engine
  logic       crc_clear;
  logic       crc_en;
  logic [7:0] crc_data;
  logic [7:0] crc_value;
  // Frame status
  logic       busy;
  logic       frame_done;
  logic       len_err;

  modport master (
    input  s_valid, s_data, s_last, m_ready, crc_value,
    output s_ready, m_valid, m_data, crc_clear, crc_en, crc_data,
           busy, frame_done, len_err
  );

  modport slave (
    output s_valid, s_data, s_last, m_ready, crc_value,
    input  s_ready, m_valid, m_data, crc_clear, crc_en, crc_data,
           busy, frame_done, len_err
  );
endinterface

`default_nettype wire

// File: rtl/uart_crc_framer.sv
// ============================================================================
//  Module      : uart_crc_framer
//  Description : Transmit-side frame sequencer. Forwards payload bytes to the
//                UART TX through a single-entry output stage, steers the
//                shared CRC-8 engine (clear at frame start, update per
//                accepted byte) and appends the CRC byte after the last
//                payload byte. Frames longer than MAX_LEN are cut at MAX_LEN
//                and flagged with len_err.
//  Ports       : clk, rst (async, active-high)
//                bus (uart_crc_framer_if.master): s_* payload in, m_* byte
//                out, crc_* engine controls, busy/frame_done/len_err status
//  Parameters  : MAX_LEN  - maximum payload bytes per frame (1..255)
//                SOF_BYTE - start-of-frame byte
//  Config      : UART_CRC_SOF_EN - when defined, SOF_BYTE is emitted ahead of
//                every payload (not covered by the CRC)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_crc_framer #(
  parameter int         MAX_LEN  = 255,
  parameter logic [7:0] SOF_BYTE = 8'h7E
) (
  input  wire logic          clk,
  input  wire logic          rst,
  uart_crc_framer_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SOF     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CRC     = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // byte_cnt value at which the accepted byte is the MAX_LEN-th one
  localparam logic [7:0] C_LAST_CNT = 8'(MAX_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       len_flag_q, len_flag_d;
  logic       m_valid_q, m_valid_d;
  logic [7:0] m_data_q, m_data_d;

  logic       can_load;
  logic       load;
  logic [7:0] load_byte;
  logic       s_ready;
  logic       crc_clear;
  logic       crc_en;
  logic [7:0] crc_data;
  logic       frame_done;
  logic       len_err;

  // The holding stage may take a new byte when empty or when its current
  // byte leaves this cycle.
  assign can_load = !m_valid_q || bus.m_ready;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_flag_d = len_flag_q;
    load       = 1'b0;
    load_byte  = SOF_BYTE;   // only actually loaded from the SOF state
    s_ready    = 1'b0;
    crc_clear  = 1'b0;
    crc_en     = 1'b0;
    crc_data   = 8'h00;
    frame_done = 1'b0;
    len_err    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Clear takes this cycle; the byte is held off until PAYLOAD so the
        // engine never sees clear and enable together.
        if (bus.s_valid) begin
          crc_clear  = 1'b1;
          byte_cnt_d = 8'h00;
`ifdef UART_CRC_SOF_EN
          state_d    = ST_SOF;
`else
          state_d    = ST_PAYLOAD;
`endif
        end
      end

`ifdef UART_CRC_SOF_EN
      ST_SOF: begin
        if (can_load) begin
          load    = 1'b1;
          state_d = ST_PAYLOAD;
        end
      end
`endif

      ST_PAYLOAD: begin
        s_ready = can_load;
        if (bus.s_valid && can_load) begin
          load       = 1'b1;
          load_byte  = bus.s_data;
          crc_en     = 1'b1;
          crc_data   = bus.s_data;
          byte_cnt_d = byte_cnt_q + 8'd1;
          if (bus.s_last) begin
            state_d = ST_CRC;
          end else if (byte_cnt_q == C_LAST_CNT) begin
            // Truncate: the remaining bytes open a new frame.
            state_d    = ST_CRC;
            len_flag_d = 1'b1;
          end
        end
      end

      ST_CRC: begin
        // Engine absorbed the final payload byte on the edge into CRC.
        if (can_load) begin
          load      = 1'b1;
          load_byte = bus.crc_value;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        // The stage holds only the CRC byte here.
        if (m_valid_q && bus.m_ready) begin
          frame_done = 1'b1;
          len_err    = len_flag_q;
          len_flag_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    m_valid_d = load ? 1'b1 : (bus.m_ready ? 1'b0 : m_valid_q);
    m_data_d  = load ? load_byte : m_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 8'h00;
      len_flag_q <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= 8'h00;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_flag_q <= len_flag_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
  end

  assign bus.s_ready    = s_ready;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_data     = m_data_q;
  assign bus.crc_clear  = crc_clear;
  assign bus.crc_en     = crc_en;
  assign bus.crc_data   = crc_data;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.frame_done = frame_done;
  assign bus.len_err    = len_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_crc_framer.sv
// ============================================================================
//  Module      : tb_uart_crc_framer
//  Description : Self-checking bench for uart_crc_framer with a CRC-8 engine
//                model on the crc_* port and a frame-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_crc_framer;

  localparam int         MAX_LEN = 4;
  localparam logic [7:0] SOF     = 8'h7E;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_crc_framer_if bus ();

  uart_crc_framer #(.MAX_LEN(MAX_LEN), .SOF_BYTE(SOF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- CRC-8 engine model (x^8+x^5+x^4+1, MSB first) ---------
  logic [7:0] crc_reg;

  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int k = 0; k < 8; k++) r = r[7] ? ((r << 1) ^ 8'h31) : (r << 1);
    return r;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst)                crc_reg <= 8'hFF;
    else if (bus.crc_clear) crc_reg <= 8'hFF;
    else if (bus.crc_en)    crc_reg <= crc_step(crc_reg, bus.crc_data);
  end
  assign bus.crc_value = crc_reg;

  // ---------------- Reference model: polynomial long division -------------
  // Preset 0xFF is folded in by inverting the first 8 message bits.
  function automatic logic [7:0] crc_ref(input logic [7:0] m[$]);
    bit         b[$];
    logic [8:0] poly;
    logic [7:0] r;
    int         n;
    poly = 9'h131;
    foreach (m[i]) for (int k = 7; k >= 0; k--) b.push_back(m[i][k]);
    for (int k = 0; k < 8; k++) b.push_back(1'b0);
    for (int k = 0; k < 8; k++) b[k] = ~b[k];
    n = b.size();
    for (int i = 0; i + 8 < n; i++)
      if (b[i]) for (int j = 0; j <= 8; j++) b[i+j] = b[i+j] ^ poly[8-j];
    for (int k = 0; k < 8; k++) r[7-k] = b[n-8+k];
    return r;
  endfunction

  // Splits a byte stream into frames (at s_last or MAX_LEN) and lists the
  // bytes the UART should see, plus expected frame and len_err counts.
  task automatic model_frames(input logic [7:0] d[$], input logic l[$],
                              output logic [7:0] e[$], output int nf, output int nle);
    logic [7:0] cur[$];
    e = {}; nf = 0; nle = 0; cur = {};
    foreach (d[i]) begin
      cur.push_back(d[i]);
      if (l[i] || cur.size() == MAX_LEN) begin
`ifdef UART_CRC_SOF_EN
        e.push_back(SOF);
`endif
        foreach (cur[j]) e.push_back(cur[j]);
        e.push_back(crc_ref(cur));
        nf++;
        if (!l[i]) nle++;
        cur = {};
      end
    end
  endtask

  // ---------------- Downstream ready generator ----------------------------
  int rdy_mode = 0;   // 0: always ready, 1: toggle, 2: random
  initial begin
    bus.m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = ~bus.m_ready;
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // ---------------- Monitor ----------------------------------------------
  logic [7:0] got[$];
  int         n_done, n_lerr, n_en, n_clr;
  logic       stall_prev = 1'b0;
  logic [7:0] held;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
      if (bus.frame_done) n_done++;
      if (bus.len_err)    n_lerr++;
      if (bus.crc_en)     n_en++;
      if (bus.crc_clear)  n_clr++;
      if (bus.crc_clear || bus.crc_en) begin
        checks++;
        if (bus.crc_clear && bus.crc_en) begin
          errors++;
          $display("FAIL crc_strobe_overlap clear=%0b en=%0b required not both", bus.crc_clear, bus.crc_en);
        end
      end
      if (bus.len_err) begin
        checks++;
        if (bus.frame_done !== 1'b1) begin
          errors++;
          $display("FAIL len_err_align frame_done=%0b required 1", bus.frame_done);
        end
      end
      if (stall_prev) begin
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_data !== held) begin
          errors++;
          $display("FAIL stall_hold m_valid=%0b m_data=%02h required 1/%02h", bus.m_valid, bus.m_data, held);
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      held       = bus.m_data;
    end
  end

  // ---------------- Helpers (stimulus only) -------------------------------
  task automatic clear_stats();
    got.delete();
    n_done = 0; n_lerr = 0; n_en = 0; n_clr = 0;
  endtask

  task automatic send(input logic [7:0] d[$], input logic l[$], input int gap_pct);
    bit ok;
    foreach (d[i]) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
      end
      bus.s_valid = 1'b1; bus.s_data = d[i]; bus.s_last = l[i];
      ok = 1'b0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (bus.s_ready) begin
          @(posedge clk); #1;
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL send_timeout byte %0d s_ready=0 required 1 within 200 cycles", i);
      end
    end
    bus.s_valid = 1'b0; bus.s_last = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!bus.busy && !bus.m_valid) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL idle_timeout busy=%0b m_valid=%0b required 0/0", bus.busy, bus.m_valid);
    end
    @(posedge clk); #1;
  endtask

  // ---------------- Tests --------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 9;
    if (bus.s_ready    !== 1'b0)  begin errors++; $display("FAIL rst_s_ready got %0b required 0", bus.s_ready); end
    if (bus.m_valid    !== 1'b0)  begin errors++; $display("FAIL rst_m_valid got %0b required 0", bus.m_valid); end
    if (bus.m_data     !== 8'h00) begin errors++; $display("FAIL rst_m_data got %02h required 00", bus.m_data); end
    if (bus.crc_clear  !== 1'b0)  begin errors++; $display("FAIL rst_crc_clear got %0b required 0", bus.crc_clear); end
    if (bus.crc_en     !== 1'b0)  begin errors++; $display("FAIL rst_crc_en got %0b required 0", bus.crc_en); end
    if (bus.crc_data   !== 8'h00) begin errors++; $display("FAIL rst_crc_data got %02h required 00", bus.crc_data); end
    if (bus.busy       !== 1'b0)  begin errors++; $display("FAIL rst_busy got %0b required 0", bus.busy); end
    if (bus.frame_done !== 1'b0)  begin errors++; $display("FAIL rst_frame_done got %0b required 0", bus.frame_done); end
    if (bus.len_err    !== 1'b0)  begin errors++; $display("FAIL rst_len_err got %0b required 0", bus.len_err); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_zero();
    logic [7:0] e[$];
    e = {8'h00, 8'hAC};
`ifdef UART_CRC_SOF_EN
    e.push_front(SOF);
`endif
    rdy_mode = 0;
    clear_stats();
    send('{8'h00}, '{1'b1}, 0);
    // Accepted byte appears on the next edge, CRC byte one cycle after.
    checks += 2;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 8'h00) begin
      errors++; $display("FAIL single_byte_latency m_valid=%0b m_data=%02h required 1/00", bus.m_valid, bus.m_data);
    end
    @(posedge clk); #1;
    if (bus.m_valid !== 1'b1 || bus.m_data !== 8'hAC) begin
      errors++; $display("FAIL single_crc_latency m_valid=%0b m_data=%02h required 1/ac", bus.m_valid, bus.m_data);
    end
    wait_idle();
    checks++;
    if (got.size() != e.size()) begin errors++; $display("FAIL single_len got %0d required %0d", got.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL single_byte[%0d] got %02h required %02h", i, got[i], e[i]); end
    end
    checks += 2;
    if (n_done != 1) begin errors++; $display("FAIL single_frame_done got %0d required 1", n_done); end
    if (n_lerr != 0) begin errors++; $display("FAIL single_len_err got %0d required 0", n_lerr); end
  endtask

  task automatic test_two_zero();
    logic [7:0] e[$];
    e = {8'h00, 8'h00, 8'h81};
`ifdef UART_CRC_SOF_EN
    e.push_front(SOF);
`endif
    rdy_mode = 0;
    clear_stats();
    send('{8'h00, 8'h00}, '{1'b0, 1'b1}, 0);
    wait_idle();
    checks++;
    if (got.size() != e.size()) begin errors++; $display("FAIL two_len got %0d required %0d", got.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL two_byte[%0d] got %02h required %02h", i, got[i], e[i]); end
    end
    checks += 3;
    if (n_en  != 2) begin errors++; $display("FAIL two_crc_en_cycles got %0d required 2", n_en); end
    if (n_clr != 1) begin errors++; $display("FAIL two_crc_clear_cycles got %0d required 1", n_clr); end
    if (n_done != 1) begin errors++; $display("FAIL two_frame_done got %0d required 1", n_done); end
  endtask

  task automatic test_stall();
    logic [7:0] e[$];
    e = {8'hFF, 8'h00};
`ifdef UART_CRC_SOF_EN
    e.push_front(SOF);
`endif
    rdy_mode = 1;
    clear_stats();
    send('{8'hFF}, '{1'b1}, 0);
    wait_idle();
    checks++;
    if (got.size() != e.size()) begin errors++; $display("FAIL stall_len got %0d required %0d", got.size(), e.size()); end
    foreach (e[i]) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL stall_byte[%0d] got %02h required %02h", i, got[i], e[i]); end
    end
    rdy_mode = 0;
  endtask

  task automatic test_max_len();
    logic [7:0] d[$], e[$];
    logic       l[$];
    int         nf, nle;
    for (int i = 0; i < 6; i++) begin
      d.push_back(8'($urandom));
      l.push_back(i == 5);
    end
    model_frames(d, l, e, nf, nle);
    rdy_mode = 0;
    clear_stats();
    send(d, l, 0);
    wait_idle();
    checks += 3;
    if (got.size() != e.size()) begin errors++; $display("FAIL maxlen_len got %0d required %0d", got.size(), e.size()); end
    if (n_done != 2) begin errors++; $display("FAIL maxlen_frames got %0d required 2", n_done); end
    if (n_lerr != 1) begin errors++; $display("FAIL maxlen_len_err got %0d required 1", n_lerr); end
    foreach (e[i]) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL maxlen_byte[%0d] got %02h required %02h", i, got[i], e[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] e[$];
    e = {8'h00, 8'hAC};
`ifdef UART_CRC_SOF_EN
    e.push_front(SOF);
`endif
    rdy_mode = 0;
    clear_stats();
    send('{8'h5A, 8'hC3}, '{1'b0, 1'b0}, 0);
    rst = 1'b1;
    @(negedge clk);
    checks += 2;
    if (bus.m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid got %0b required 0", bus.m_valid); end
    if (bus.busy    !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b required 0", bus.busy); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (n_done != 0) begin errors++; $display("FAIL midrst_frame_done got %0d required 0", n_done); end
    clear_stats();
    send('{8'h00}, '{1'b1}, 0);
    wait_idle();
    checks += 2;
    if (got.size() != e.size()) begin errors++; $display("FAIL midrst_len got %0d required %0d", got.size(), e.size()); end
    if (n_clr != 1) begin errors++; $display("FAIL midrst_crc_clear got %0d required 1", n_clr); end
    foreach (e[i]) begin
      checks++;
      if (got[i] !== e[i]) begin errors++; $display("FAIL midrst_byte[%0d] got %02h required %02h", i, got[i], e[i]); end
    end
  endtask

  task automatic test_random();
    rdy_mode = 2;
    for (int it = 0; it < 12; it++) begin
      logic [7:0] d[$], e[$];
      logic       l[$];
      int         n, nf, nle;
      n = $urandom_range(1, 9);
      for (int i = 0; i < n; i++) begin
        d.push_back(8'($urandom));
        l.push_back(i == n - 1);
      end
      model_frames(d, l, e, nf, nle);
      clear_stats();
      send(d, l, 30);
      wait_idle();
      checks += 5;
      if (got.size() != e.size()) begin errors++; $display("FAIL rand%0d_len got %0d required %0d", it, got.size(), e.size()); end
      if (n_done != nf)  begin errors++; $display("FAIL rand%0d_frames got %0d required %0d", it, n_done, nf); end
      if (n_lerr != nle) begin errors++; $display("FAIL rand%0d_len_err got %0d required %0d", it, n_lerr, nle); end
      if (n_clr != nf)   begin errors++; $display("FAIL rand%0d_crc_clear got %0d required %0d", it, n_clr, nf); end
      if (n_en != n)     begin errors++; $display("FAIL rand%0d_crc_en got %0d required %0d", it, n_en, n); end
      foreach (e[i]) begin
        checks++;
        if (got[i] !== e[i]) begin errors++; $display("FAIL rand%0d_byte[%0d] got %02h required %02h", it, i, got[i], e[i]); end
      end
    end
    rdy_mode = 0;
  endtask

  // ---------------- Sequence ----------------------------------------------
  initial begin
    rst = 1'b1;
    bus.s_valid = 1'b0; bus.s_data = 8'h00; bus.s_last = 1'b0;
    test_reset();
    test_single_zero();
    test_two_zero();
    test_stall();
    test_max_len();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/uart_crc_framer.md
# uart_crc_framer

Transmit-side frame sequencer between a byte-stream producer and the UART transmitter. Accepts payload bytes with an end-of-frame marker, forwards them unchanged, and drives the shared byte-wide CRC-8 engine (x^8+x^5+x^4+1, init 0xFF, no final XOR): clears it at frame start and enables it per accepted byte. After the last payload byte it appends the CRC byte. It also enforces a maximum frame length.

## Interface
- MAX_LEN, 255: maximum payload bytes per frame, 1..255.
- SOF_BYTE, 8'h7E: start-of-frame byte, used only with the configuration macro.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- s_valid  in  1  payload byte valid.
- s_data  in  8  payload byte.
- s_last  in  1  byte is the final payload byte of the frame.
- s_ready  out  1  framer accepts s_data this cycle.
- m_valid  out  1  output byte valid, toward UART TX.
- m_data  out  8  output byte.
- m_ready  in  1  UART TX accepts m_data.
- crc_clear  out  1  CRC engine reset-to-0xFF strobe.
- crc_en  out  1  CRC engine update strobe.
- crc_data  out  8  byte fed to the CRC engine.
- crc_value  in  8  current CRC engine register.
- busy  out  1  frame in progress (state != IDLE).
- frame_done  out  1  one-cycle pulse when the CRC byte is accepted downstream.
- len_err  out  1  pulse coincident with frame_done when the frame was truncated at MAX_LEN.

## Operation
- States: IDLE, SOF (macro only), PAYLOAD, CRC, DONE.
- Output register: single-entry holding stage (m_valid/m_data). It loads when the stage is empty or m_ready=1. A transfer occurs on m_valid&&m_ready.
- IDLE: s_ready=0. On s_valid=1, assert crc_clear for one cycle, clear byte_cnt, then go to SOF or PAYLOAD. The byte is not consumed in IDLE, because clear has priority over enable in the engine.
- SOF: load SOF_BYTE into the output stage when it can load, with no crc_en, then go to PAYLOAD.
- PAYLOAD: s_ready = stage can load. On accept, load m_data<=s_data, set crc_en=1 and crc_data=s_data combinationally in the same cycle, and increment byte_cnt.
  - Go to CRC on accept with s_last=1.
  - Also go to CRC on accept with byte_cnt reaching MAX_LEN. If s_last=0 at that point, set the len_err flag. Following bytes begin a new frame.
- CRC: s_ready=0. When the stage can load, load m_data<=crc_value, then go to DONE. crc_value is valid here because the engine updated at the edge that entered CRC.
- DONE: wait for the CRC byte transfer. That cycle pulses frame_done (and len_err if flagged), clears the flag, and returns to IDLE.
- crc_clear and crc_en are never asserted in the same cycle. crc_en is asserted only in PAYLOAD on accept.
- byte_cnt is 8 bits and cannot wrap, because MAX_LEN<=255 forces the transition.

## Timing
- Reset values: s_ready=0, m_valid=0, m_data=8'h00, crc_clear=0, crc_en=0, crc_data=8'h00, busy=0, frame_done=0, len_err=0; state=IDLE, byte_cnt=0, len_err flag=0.
- Latency:
  - s_valid seen in IDLE → first payload accept no earlier than 1 cycle later (2 with SOF).
  - Accepted byte → m_valid on next edge.
  - Last accept → CRC byte valid 1 cycle later if downstream is ready.
- Full throughput with m_ready held high: one byte per cycle in PAYLOAD. Frame overhead is 2 cycles (3 with SOF), plus 1 cycle for DONE.
- m_data and m_valid are stable while m_valid=1 and m_ready=0.
- Reset mid-frame: immediate return to IDLE, output stage emptied, no frame_done. The next frame starts with crc_clear.
- s_valid deasserted mid-frame: the framer waits in PAYLOAD indefinitely. No timeout.

## Configuration
- UART_CRC_SOF_EN defined: SOF state present. SOF_BYTE is emitted before each payload and is excluded from the CRC.
- UART_CRC_SOF_EN undefined: IDLE goes directly to PAYLOAD. SOF_BYTE is unused.

## Test plan
All scenarios use the bench CRC-8 engine model connected to crc_clear, crc_en, crc_data and crc_value.
- Payload {0x00}, s_last on byte 1, m_ready=1 → output 0x00, 0xAC; one frame_done; len_err=0.
- Payload {0x00,0x00} → output 0x00, 0x00, 0x81; crc_en high exactly 2 cycles; crc_clear high exactly 1 cycle.
- Payload {0xFF} with m_ready toggling 1/0 each cycle → output 0xFF, 0x00; m_data stable while stalled.
- MAX_LEN=4, 6 bytes, no s_last → frame 1 = 4 bytes + CRC with len_err pulse. Frame 2 = 2 bytes (last on byte 6) + CRC with len_err=0.
- rst pulsed after 2 payload bytes of a 5-byte frame → m_valid=0, busy=0 next cycle, no frame_done. A fresh {0x00} frame then yields CRC 0xAC.
- UART_CRC_SOF_EN defined, payload {0x00} → output 0x7E, 0x00, 0xAC.
